swervolf_ram_init: RTL and testbench



---
 rtl/swervolf_ram_init_pkg.sv | 26 ++
 rtl/swervolf_ram_init.sv | 205 ++++++++++++++++++++
 tb/tb_swervolf_ram_init.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/swervolf_ram_init_pkg.sv
// Shared definitions for the RAM bring-up sequencer: state codes, fixed AXI
// field values and the address-derived fill pattern.
package swervolf_ram_init_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_WR_AW = 3'd1;
    localparam state_t ST_WR_W  = 3'd2;
    localparam state_t ST_WR_B  = 3'd3;
    localparam state_t ST_RD_AR = 3'd4;
    localparam state_t ST_RD_R  = 3'd5;
    localparam state_t ST_DONE  = 3'd6;
    localparam state_t ST_ERR   = 3'd7;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_8B    = 3'b011;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // Fill word for the 8-byte beat at byte address addr: inverted address
    // in the upper half so stuck or aliased address lines are caught.
    function automatic logic [63:0] init_pattern(input logic [31:0] addr);
        return {~addr, addr};
    endfunction

endpackage

// File: rtl/swervolf_ram_init.sv
// RAM bring-up sequencer: owns the main-memory AXI port after reset, fills
// the memory with init_pattern() using INCR bursts, optionally reads it back
// and checks it, then reports done/error to the core.
module swervolf_ram_init
    import swervolf_ram_init_pkg::*;
#(
    parameter int ID_WIDTH  = 6,
    parameter int MEM_SIZE  = 32'h10000,
    parameter int BURST_LEN = 16,
    parameter int VERIFY    = 1
) (
    input  logic                clk,
    input  logic                rst,
    output logic [ID_WIDTH-1:0] o_ram_awid,
    output logic [31:0]         o_ram_awaddr,
    output logic [7:0]          o_ram_awlen,
    output logic [2:0]          o_ram_awsize,
    output logic [1:0]          o_ram_awburst,
    output logic                o_ram_awvalid,
    input  logic                i_ram_awready,
    output logic [63:0]         o_ram_wdata,
    output logic [7:0]          o_ram_wstrb,
    output logic                o_ram_wlast,
    output logic                o_ram_wvalid,
    input  logic                i_ram_wready,
    input  logic [ID_WIDTH-1:0] i_ram_bid,
    input  logic [1:0]          i_ram_bresp,
    input  logic                i_ram_bvalid,
    output logic                o_ram_bready,
    output logic [ID_WIDTH-1:0] o_ram_arid,
    output logic [31:0]         o_ram_araddr,
    output logic [7:0]          o_ram_arlen,
    output logic [2:0]          o_ram_arsize,
    output logic [1:0]          o_ram_arburst,
    output logic                o_ram_arvalid,
    input  logic                i_ram_arready,
    input  logic [ID_WIDTH-1:0] i_ram_rid,
    input  logic [63:0]         i_ram_rdata,
    input  logic [1:0]          i_ram_rresp,
    input  logic                i_ram_rlast,
    input  logic                i_ram_rvalid,
    output logic                o_ram_rready,
    output logic                o_ram_init_done,
    output logic                o_ram_init_error,
    output logic [31:0]         o_err_addr
);

    localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 8);
    localparam logic [31:0] MEM_BYTES   = 32'(MEM_SIZE);
    localparam logic [7:0]  LAST_BEAT   = 8'(BURST_LEN - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  beat_q, beat_d;
    logic        awvalid_q, awvalid_d;
    logic        arvalid_q, arvalid_d;
    logic        rd_err_q, rd_err_d;
    logic [31:0] err_addr_q, err_addr_d;

    logic [31:0] beat_addr;
    logic        last_burst;
    logic        wr_resp_bad;
    logic        rd_last_exp;
    logic        rd_beat_bad;
    logic        rd_burst_end;

    // Byte address of the current beat within the open burst.
    assign beat_addr    = addr_q + {21'd0, beat_q, 3'd0};
    assign last_burst   = (addr_q + BURST_BYTES) == MEM_BYTES;
    assign wr_resp_bad  = (i_ram_bresp != RESP_OKAY) || (i_ram_bid != '0);
    assign rd_last_exp  = (beat_q == LAST_BEAT);
    assign rd_beat_bad  = (i_ram_rresp != RESP_OKAY) || (i_ram_rid != '0)
                       || (i_ram_rdata != init_pattern(beat_addr))
                       || (i_ram_rlast != rd_last_exp);
    // A premature rlast still closes the burst so the slave is never stalled.
    assign rd_burst_end = i_ram_rlast || rd_last_exp;

    // Next-state logic: one burst outstanding at a time, AW strictly before W.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        beat_d     = beat_q;
        awvalid_d  = awvalid_q;
        arvalid_d  = arvalid_q;
        rd_err_d   = rd_err_q;
        err_addr_d = err_addr_q;
        case (state_q)
            ST_IDLE: begin
                addr_d  = '0;
                beat_d  = '0;
                state_d = ST_WR_AW;
            end
            ST_WR_AW: begin
                if (awvalid_q && i_ram_awready) begin
                    awvalid_d = 1'b0;
                    beat_d    = '0;
                    state_d   = ST_WR_W;
                end else begin
                    awvalid_d = 1'b1;
                end
            end
            ST_WR_W: begin
                if (i_ram_wready) begin
                    beat_d = beat_q + 8'd1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_WR_B;
                    end
                end
            end
            ST_WR_B: begin
                if (i_ram_bvalid) begin
                    if (wr_resp_bad) begin
                        err_addr_d = addr_q;
                        state_d    = ST_ERR;
                    end else if (last_burst) begin
                        addr_d  = '0;
                        state_d = (VERIFY != 0) ? ST_RD_AR : ST_DONE;
                    end else begin
                        addr_d  = addr_q + BURST_BYTES;
                        state_d = ST_WR_AW;
                    end
                end
            end
            ST_RD_AR: begin
                if (arvalid_q && i_ram_arready) begin
                    arvalid_d = 1'b0;
                    beat_d    = '0;
                    rd_err_d  = 1'b0;
                    state_d   = ST_RD_R;
                end else begin
                    arvalid_d = 1'b1;
                end
            end
            ST_RD_R: begin
                if (i_ram_rvalid) begin
                    beat_d = beat_q + 8'd1;
                    if (rd_beat_bad && !rd_err_q) begin
                        rd_err_d   = 1'b1;
                        err_addr_d = beat_addr;
                    end
                    if (rd_burst_end) begin
                        if (rd_err_q || rd_beat_bad) begin
                            state_d = ST_ERR;
                        end else if (last_burst) begin
                            state_d = ST_DONE;
                        end else begin
                            addr_d  = addr_q + BURST_BYTES;
                            state_d = ST_RD_AR;
                        end
                    end
                end
            end
            ST_DONE, ST_ERR: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            beat_q     <= '0;
            awvalid_q  <= 1'b0;
            arvalid_q  <= 1'b0;
            rd_err_q   <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            beat_q     <= beat_d;
            awvalid_q  <= awvalid_d;
            arvalid_q  <= arvalid_d;
            rd_err_q   <= rd_err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign o_ram_awid       = '0;
    assign o_ram_awaddr     = addr_q;
    assign o_ram_awlen      = LAST_BEAT;
    assign o_ram_awsize     = SIZE_8B;
    assign o_ram_awburst    = BURST_INCR;
    assign o_ram_awvalid    = awvalid_q;
    assign o_ram_wdata      = init_pattern(beat_addr);
    assign o_ram_wstrb      = 8'hFF;
    assign o_ram_wlast      = (beat_q == LAST_BEAT);
    assign o_ram_wvalid     = (state_q == ST_WR_W);
    assign o_ram_bready     = (state_q == ST_WR_B);
    assign o_ram_arid       = '0;
    assign o_ram_araddr     = addr_q;
    assign o_ram_arlen      = LAST_BEAT;
    assign o_ram_arsize     = SIZE_8B;
    assign o_ram_arburst    = BURST_INCR;
    assign o_ram_arvalid    = arvalid_q;
    assign o_ram_rready     = (state_q == ST_RD_R);
    assign o_ram_init_done  = (state_q == ST_DONE) || (state_q == ST_ERR);
    assign o_ram_init_error = (state_q == ST_ERR);
    assign o_err_addr       = err_addr_q;

endmodule

// File: tb/tb_swervolf_ram_init.sv
// Bench for swervolf_ram_init: a behavioural AXI slave with optional random
// backpressure and fault injection, a scoreboard of expected AW/W/AR traffic
// and final status, plus a second instance built without the read-back pass.
`timescale 1ns/1ps
module tb_swervolf_ram_init;

    localparam int ID_W = 6;
    localparam int MEM  = 32'h400;
    localparam int BL   = 16;
    localparam int NB   = MEM / (BL * 8);
    localparam int NW   = MEM / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    // main instance (read-back enabled)
    logic [ID_W-1:0] awid, arid;
    logic [31:0]     awaddr, araddr, err_addr;
    logic [7:0]      awlen, arlen, wstrb;
    logic [2:0]      awsize, arsize;
    logic [1:0]      awburst, arburst;
    logic            awvalid, arvalid, wlast, wvalid, bready, rready, done, error;
    logic [63:0]     wdata;
    logic            awready = 1'b0, wready = 1'b0, arready = 1'b0;
    logic [ID_W-1:0] bid = '0, rid = '0;
    logic [1:0]      bresp = 2'b00, rresp = 2'b00;
    logic            bvalid = 1'b0, rvalid = 1'b0, rlast = 1'b0;
    logic [63:0]     rdata = '0;

    swervolf_ram_init #(.ID_WIDTH(ID_W), .MEM_SIZE(MEM), .BURST_LEN(BL), .VERIFY(1)) dut (
        .clk(clk), .rst(rst),
        .o_ram_awid(awid), .o_ram_awaddr(awaddr), .o_ram_awlen(awlen), .o_ram_awsize(awsize),
        .o_ram_awburst(awburst), .o_ram_awvalid(awvalid), .i_ram_awready(awready),
        .o_ram_wdata(wdata), .o_ram_wstrb(wstrb), .o_ram_wlast(wlast), .o_ram_wvalid(wvalid),
        .i_ram_wready(wready), .i_ram_bid(bid), .i_ram_bresp(bresp), .i_ram_bvalid(bvalid),
        .o_ram_bready(bready), .o_ram_arid(arid), .o_ram_araddr(araddr), .o_ram_arlen(arlen),
        .o_ram_arsize(arsize), .o_ram_arburst(arburst), .o_ram_arvalid(arvalid),
        .i_ram_arready(arready), .i_ram_rid(rid), .i_ram_rdata(rdata), .i_ram_rresp(rresp),
        .i_ram_rlast(rlast), .i_ram_rvalid(rvalid), .o_ram_rready(rready),
        .o_ram_init_done(done), .o_ram_init_error(error), .o_err_addr(err_addr)
    );

    // second instance (no read-back), always-ready slave
    logic            n_rst = 1'b1;
    logic [ID_W-1:0] n_awid, n_arid;
    logic [31:0]     n_awaddr, n_araddr, n_err_addr;
    logic [7:0]      n_awlen, n_arlen, n_wstrb;
    logic [2:0]      n_awsize, n_arsize;
    logic [1:0]      n_awburst, n_arburst;
    logic            n_awvalid, n_arvalid, n_wlast, n_wvalid, n_bready, n_rready, n_done, n_error;
    logic [63:0]     n_wdata;
    logic            n_awready = 1'b1, n_wready = 1'b1, n_arready = 1'b1;
    logic [ID_W-1:0] n_bid = '0, n_rid = '0;
    logic [1:0]      n_bresp = 2'b00, n_rresp = 2'b00;
    logic            n_bvalid = 1'b0, n_rvalid = 1'b0, n_rlast = 1'b0;
    logic [63:0]     n_rdata = '0;

    swervolf_ram_init #(.ID_WIDTH(ID_W), .MEM_SIZE(MEM), .BURST_LEN(BL), .VERIFY(0)) dut_nv (
        .clk(clk), .rst(n_rst),
        .o_ram_awid(n_awid), .o_ram_awaddr(n_awaddr), .o_ram_awlen(n_awlen), .o_ram_awsize(n_awsize),
        .o_ram_awburst(n_awburst), .o_ram_awvalid(n_awvalid), .i_ram_awready(n_awready),
        .o_ram_wdata(n_wdata), .o_ram_wstrb(n_wstrb), .o_ram_wlast(n_wlast), .o_ram_wvalid(n_wvalid),
        .i_ram_wready(n_wready), .i_ram_bid(n_bid), .i_ram_bresp(n_bresp), .i_ram_bvalid(n_bvalid),
        .o_ram_bready(n_bready), .o_ram_arid(n_arid), .o_ram_araddr(n_araddr), .o_ram_arlen(n_arlen),
        .o_ram_arsize(n_arsize), .o_ram_arburst(n_arburst), .o_ram_arvalid(n_arvalid),
        .i_ram_arready(n_arready), .i_ram_rid(n_rid), .i_ram_rdata(n_rdata), .i_ram_rresp(n_rresp),
        .i_ram_rlast(n_rlast), .i_ram_rvalid(n_rvalid), .o_ram_rready(n_rready),
        .o_ram_init_done(n_done), .o_ram_init_error(n_error), .o_err_addr(n_err_addr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    function automatic logic [63:0] ref_pattern(input logic [31:0] a);
        return {~a, a};
    endfunction

    logic [31:0] exp_aw_q[$];
    logic [31:0] exp_ar_q[$];
    logic [64:0] exp_w_q[$];
    logic        exp_err;
    logic [31:0] exp_err_addr;
    int          exp_r_beats;

    // Expected traffic: every burst written in address order; a failed write
    // response ends the run after that burst; reads stop at the burst that
    // holds the corrupted beat.
    task automatic expect_run(input int fail_burst, input int bad_addr);
        exp_aw_q.delete();
        exp_w_q.delete();
        exp_ar_q.delete();
        exp_err      = 1'b0;
        exp_err_addr = '0;
        exp_r_beats  = 0;
        for (int b = 0; b < NB; b++) begin
            if (fail_burst >= 0 && b > fail_burst) break;
            exp_aw_q.push_back(32'(b * BL * 8));
            for (int k = 0; k < BL; k++)
                exp_w_q.push_back({k == BL - 1, ref_pattern(32'(b * BL * 8 + k * 8))});
        end
        if (fail_burst >= 0) begin
            exp_err      = 1'b1;
            exp_err_addr = 32'(fail_burst * BL * 8);
            return;
        end
        for (int b = 0; b < NB; b++) begin
            exp_ar_q.push_back(32'(b * BL * 8));
            exp_r_beats += BL;
            if (bad_addr >= b * BL * 8 && bad_addr < (b + 1) * BL * 8) begin
                exp_err      = 1'b1;
                exp_err_addr = 32'(bad_addr);
                break;
            end
        end
    endtask

    // ---------------- behavioural slave for the main instance ----------------
    logic [63:0] mem [0:NW-1];
    bit          cfg_bp = 1'b0;
    int          cfg_fail_burst = -1;
    int          cfg_bad_addr = -1;
    logic        aw_hs, w_hs, b_hs, ar_hs, r_hs, s_in_rst;
    logic [31:0] s_w_addr, s_r_addr, s_a;
    int          s_w_cnt, s_r_cnt, s_b_idx, s_idx, w_total, r_total;
    bit          s_b_pend, s_rd_act;

    initial begin : slave
        for (int i = 0; i < NW; i++) mem[i] = '0;
        forever begin
            // handshakes resolved at the coming rising edge
            @(negedge clk);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            b_hs  = bvalid && bready;
            ar_hs = arvalid && arready;
            r_hs  = rvalid && rready;
            s_in_rst = rst;
            if (rst) begin
                s_w_cnt = 0; s_r_cnt = 0; s_b_idx = 0; s_b_pend = 0; s_rd_act = 0;
                w_total = 0; r_total = 0;
            end else begin
                if (aw_hs) begin s_w_addr = awaddr; s_w_cnt = 0; end
                if (w_hs) begin
                    s_idx = int'(s_w_addr >> 3) + s_w_cnt;
                    if (s_idx < NW) mem[s_idx] = wdata;
                    s_w_cnt++;
                    w_total++;
                    if (wlast) s_b_pend = 1'b1;
                end
                if (b_hs) s_b_idx++;
                if (ar_hs) begin s_r_addr = araddr; s_r_cnt = 0; s_rd_act = 1'b1; end
                if (r_hs) begin
                    s_r_cnt++;
                    r_total++;
                    if (s_r_cnt == BL) s_rd_act = 1'b0;
                end
            end
            @(posedge clk);
            #1;
            awready = cfg_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            wready  = cfg_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            arready = cfg_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (s_in_rst) begin
                bvalid = 1'b0; rvalid = 1'b0; rlast = 1'b0;
            end else begin
                if (b_hs) bvalid = 1'b0;
                if (!bvalid && s_b_pend && (!cfg_bp || $urandom_range(0, 1) == 1)) begin
                    bvalid   = 1'b1;
                    bresp    = (s_b_idx == cfg_fail_burst) ? 2'b10 : 2'b00;
                    s_b_pend = 1'b0;
                end
                if (r_hs) rvalid = 1'b0;
                if (!rvalid && s_rd_act && s_r_cnt < BL && (!cfg_bp || $urandom_range(0, 2) != 0)) begin
                    s_a   = s_r_addr + 32'(s_r_cnt * 8);
                    s_idx = int'(s_a >> 3);
                    rdata = (s_idx < NW) ? mem[s_idx] : '0;
                    if (int'(s_a) == cfg_bad_addr) rdata = rdata ^ 64'h1;
                    rlast  = (s_r_cnt == BL - 1);
                    rvalid = 1'b1;
                end
            end
        end
    end

    // ---------------- monitor: pops expectations on DUT handshakes ----------------
    logic        last_rst = 1'b0;
    logic        aw_stall = 1'b0, w_stall = 1'b0, ar_stall = 1'b0;
    logic [31:0] aw_prev, ar_prev, exp_a;
    logic [64:0] w_prev, exp_wv;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (last_rst) begin
                check("reset_outputs", {awvalid, wvalid, arvalid, bready, rready, done, error}, 7'd0);
                check("reset_err_addr", err_addr, 32'd0);
            end
            last_rst = rst;
            if (rst) begin
                aw_stall = 1'b0; w_stall = 1'b0; ar_stall = 1'b0;
            end else begin
                if (aw_stall) check("aw_stable", {awvalid, awaddr}, {1'b1, aw_prev});
                if (w_stall)  check("w_stable", {wvalid, wlast, wdata}, {1'b1, w_prev});
                if (ar_stall) check("ar_stable", {arvalid, araddr}, {1'b1, ar_prev});
                if (awvalid && awready) begin
                    if (exp_aw_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL aw_unexpected: got AW at 0x%0h, required no AW", awaddr);
                    end else begin
                        exp_a = exp_aw_q.pop_front();
                        $display("AW addr=0x%08h len=%0d", awaddr, awlen);
                        check("aw", {awid, awaddr, awlen, awsize, awburst},
                              {6'd0, exp_a, 8'(BL - 1), 3'd3, 2'd1});
                    end
                end
                if (wvalid && wready) begin
                    if (exp_w_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL w_unexpected: got W data 0x%0h, required no W", wdata);
                    end else begin
                        exp_wv = exp_w_q.pop_front();
                        check("w", {wlast, wstrb, wdata}, {exp_wv[64], 8'hFF, exp_wv[63:0]});
                    end
                end
                if (arvalid && arready) begin
                    if (exp_ar_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL ar_unexpected: got AR at 0x%0h, required no AR", araddr);
                    end else begin
                        exp_a = exp_ar_q.pop_front();
                        $display("AR addr=0x%08h len=%0d", araddr, arlen);
                        check("ar", {arid, araddr, arlen, arsize, arburst},
                              {6'd0, exp_a, 8'(BL - 1), 3'd3, 2'd1});
                    end
                end
                aw_stall = awvalid && !awready;
                aw_prev  = awaddr;
                w_stall  = wvalid && !wready;
                w_prev   = {wlast, wdata};
                ar_stall = arvalid && !arready;
                ar_prev  = araddr;
            end
        end
    end

    // ---------------- no-read-back instance ----------------
    int  n_aw_cnt = 0, n_w_cnt = 0, n_b_cnt = 0;
    bit  n_b_pend = 1'b0, n_expect_done = 1'b0, n_finished = 1'b0;
    logic n_b_hs;

    initial begin : nv_run
        repeat (3) @(posedge clk);
        #1;
        n_rst = 1'b0;
        for (int cyc = 0; cyc < 3000 && !n_finished; cyc++) begin
            @(negedge clk);
            if (n_expect_done) begin
                check("nv_done_after_last_b", {n_done, n_error, n_err_addr}, {2'b10, 32'd0});
                n_finished = 1'b1;
            end
            check("nv_no_read", {n_arvalid, n_rready}, 2'b00);
            if (n_arvalid)
                $display("nv AR id=%0h addr=0x%0h len=%0d size=%0d burst=%0d",
                         n_arid, n_araddr, n_arlen, n_arsize, n_arburst);
            n_b_hs = n_bvalid && n_bready;
            if (n_awvalid) begin
                check("nv_aw", {n_awid, n_awaddr, n_awlen, n_awsize, n_awburst},
                      {6'd0, 32'(n_aw_cnt * BL * 8), 8'(BL - 1), 3'd3, 2'd1});
                n_aw_cnt++;
            end
            if (n_wvalid) begin
                check("nv_w", {n_wlast, n_wstrb, n_wdata},
                      {(n_w_cnt % BL) == BL - 1, 8'hFF, ref_pattern(32'(n_w_cnt * 8))});
                n_w_cnt++;
                if (n_wlast) n_b_pend = 1'b1;
            end
            if (n_b_hs) begin
                n_b_cnt++;
                if (n_b_cnt == NB) begin
                    check("nv_done_early", n_done, 1'b0);
                    n_expect_done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            if (n_b_hs) n_bvalid = 1'b0;
            if (n_b_pend && !n_bvalid) begin n_bvalid = 1'b1; n_b_pend = 1'b0; end
        end
    end

    // ---------------- scenarios on the main instance ----------------
    task automatic run_scenario(input string name, input bit bp, input int fail_burst,
                                input int bad_addr, input int rst_beat);
        bit got;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cfg_bp = bp;
        cfg_fail_burst = fail_burst;
        cfg_bad_addr = bad_addr;
        expect_run(fail_burst, bad_addr);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        if (rst_beat >= 0) begin
            got = 1'b0;
            for (int i = 0; i < 5000 && !got; i++) begin
                @(posedge clk);
                #1;
                if (w_total == rst_beat) got = 1'b1;
            end
            check({name, "_reset_point"}, got, 1'b1);
            rst = 1'b1;
            expect_run(fail_burst, bad_addr);
            @(posedge clk);
            #1;
            rst = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < 8000 && !got; i++) begin
            @(posedge clk);
            #1;
            if (done) got = 1'b1;
        end
        check({name, "_done_seen"}, got, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check({name, "_status"}, {done, error}, {1'b1, exp_err});
        check({name, "_err_addr"}, err_addr, exp_err_addr);
        check({name, "_aw_left"}, exp_aw_q.size(), 0);
        check({name, "_w_left"}, exp_w_q.size(), 0);
        check({name, "_ar_left"}, exp_ar_q.size(), 0);
        check({name, "_r_beats"}, r_total, exp_r_beats);
        if (!exp_err) check({name, "_word_208"}, mem[32'h208 >> 3], 64'hFFFFFDF7_00000208);
        $display("scenario %s complete: done=%0d error=%0d err_addr=0x%0h", name, done, error, err_addr);
    endtask

    initial begin : stimulus
        run_scenario("clean",        1'b0, -1, -1,     -1);
        run_scenario("backpressure", 1'b1, -1, -1,     -1);
        run_scenario("bresp_err",    1'b1,  3, -1,     -1);
        run_scenario("rd_corrupt",   1'b1, -1, 'h208,  -1);
        run_scenario("mid_reset",    1'b0, -1, -1,     2 * BL + 5);
        check("nv_finished", n_finished, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
